// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM decoder: FSM encoding, default sizing and
// the MA drive-pair decode constants.
package pwm_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 2000;

  localparam logic [1:0] MA_OFF = 2'b00;
  localparam logic [1:0] MA_FWD = 2'b10;
  localparam logic [1:0] MA_REV = 2'b01;
  localparam logic [1:0] MA_BRK = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  // Both drive codes carry an active PWM high phase; brake and off do not.
  function automatic logic ma_is_pulse(input logic [1:0] ma);
    return (ma == MA_FWD) || (ma == MA_REV);
  endfunction

endpackage

// File: rtl/pwm_sync_filter.sv
// Two-flop synchronizer for the MA pair; when PWM_DEC_FILTER_EN is defined a
// glitch filter follows that passes a value only after 3 identical samples.
module pwm_sync_filter
  import pwm_pkg::*;
(
  input  logic       div100_clk,
  input  logic       s_rst_n,
  input  logic [1:0] ma,
  output logic [1:0] ma_s
);

  logic [1:0] sync1;
  logic [1:0] sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes the chain a chain.
  always_ff @(posedge div100_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sync1 <= MA_OFF;
      sync2 <= MA_OFF;
    end else begin
      sync1 <= ma;
      sync2 <= sync1;
    end
  end

`ifdef PWM_DEC_FILTER_EN
  logic [1:0] hist1;
  logic [1:0] hist2;
  logic [1:0] held;
  logic       stable;

  // The newest sample joins two history taps; accept only when all three agree.
  assign stable = (sync2 == hist1) && (hist1 == hist2);
  assign ma_s   = stable ? sync2 : held;

  always_ff @(posedge div100_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      hist1 <= MA_OFF;
      hist2 <= MA_OFF;
      held  <= MA_OFF;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
      held  <= ma_s;
    end
  end
`else
  assign ma_s = sync2;
`endif

endmodule

// File: rtl/pwm_decoder.sv
// Decodes a motor-drive PWM pair into direction, enable, duty and period, with
// a sticky stall flag. Optional glitch filter: define PWM_DEC_FILTER_EN.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             div100_clk,
  input  logic             s_rst_n,
  input  logic [1:0]       MA,
  input  logic             clr,
  output logic [CNT_W-1:0] duty,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             direct,
  output logic             active,
  output logic             stall
);

  logic [1:0]       ma_s;
  logic             en_r;
  logic             pulse_r;
  logic             pulse_q;
  logic             dir_r;
  logic             dir_q;
  logic             ma_off;
  logic             rise;
  logic             fall;
  logic             dir_change;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] high_next;
  logic             load;
  logic             timeout;

  pwm_sync_filter u_sync (
    .div100_clk (div100_clk),
    .s_rst_n    (s_rst_n),
    .ma         (MA),
    .ma_s       (ma_s)
  );

  // Decode register: the third cycle of MA-to-pulse latency.
  always_ff @(posedge div100_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      en_r    <= 1'b0;
      pulse_r <= 1'b0;
      pulse_q <= 1'b0;
      dir_r   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      en_r    <= (ma_s != MA_OFF);
      pulse_r <= ma_is_pulse(ma_s);
      pulse_q <= pulse_r;
      dir_q   <= dir_r;
      if (ma_s == MA_FWD)      dir_r <= 1'b1;
      else if (ma_s == MA_REV) dir_r <= 1'b0;
    end
  end

  // Disable acts straight off the decoder input so IDLE and the zeroed
  // outputs land on the same edge as active falling.
  assign ma_off     = (ma_s == MA_OFF);
  assign rise       = pulse_r & ~pulse_q;
  assign fall       = ~pulse_r & pulse_q;
  assign dir_change = dir_r ^ dir_q;
  assign cnt_inc    = (&cnt) ? cnt : cnt + 1'b1;

  assign direct = dir_r;
  assign active = en_r;

  always_ff @(posedge div100_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      high_time <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      high_time <= high_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    high_next  = high_time;
    load       = 1'b0;
    timeout    = 1'b0;

    if (ma_off) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_next = '0;
          if (en_r) state_next = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (!dir_change && rise) begin
            cnt_next   = '0;
            state_next = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          cnt_next = cnt_inc;
          if (dir_change) begin
            state_next = WAIT_RISE;
          end else if (fall) begin
            high_next  = cnt_inc;
            state_next = MEAS_LOW;
          end else if (32'(cnt_inc) >= TIMEOUT) begin
            timeout    = 1'b1;
            state_next = WAIT_RISE;
          end
        end
        MEAS_LOW: begin
          cnt_next = cnt_inc;
          if (dir_change) begin
            state_next = WAIT_RISE;
          end else if (rise) begin
            load       = 1'b1;
            cnt_next   = '0;
            state_next = MEAS_HIGH;
          end else if (32'(cnt_inc) >= TIMEOUT) begin
            timeout    = 1'b1;
            state_next = WAIT_RISE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // clr outranks a same-cycle load; a later load never clears stall.
  always_ff @(posedge div100_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      duty   <= '0;
      period <= '0;
      valid  <= 1'b0;
      stall  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clr) begin
        duty   <= '0;
        period <= '0;
        stall  <= 1'b0;
      end else if (ma_off) begin
        duty   <= '0;
        period <= '0;
      end else begin
        if (load) begin
          duty   <= high_time;
          period <= cnt_inc;
          valid  <= 1'b1;
        end
        if (timeout) stall <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: a table of steady PWM waveforms plus
// hand-written sequences for direction switch, stall, clr, disable and reset.
module tb_pwm_decoder;

  localparam int TO = 2000;
`ifdef PWM_DEC_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        div100_clk = 1'b0;
  logic        s_rst_n    = 1'b0;
  logic [1:0]  MA         = 2'b00;
  logic        clr        = 1'b0;
  logic [15:0] duty;
  logic [15:0] period;
  logic        valid;
  logic        direct;
  logic        active;
  logic        stall;

  pwm_decoder #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .div100_clk (div100_clk),
    .s_rst_n    (s_rst_n),
    .MA         (MA),
    .clr        (clr),
    .duty       (duty),
    .period     (period),
    .valid      (valid),
    .direct     (direct),
    .active     (active),
    .stall      (stall)
  );

  always #5 div100_clk = ~div100_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int vcount;
  int first_duty, first_period;
  int last_duty, last_period;
  logic last_dir;

  typedef struct {
    logic [1:0] code;
    int         hi_len;
    int         lo_len;
    int         exp_duty;
    int         exp_period;
    logic       exp_dir;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic capture_clear();
    vcount = 0;
    first_duty = -1; first_period = -1;
    last_duty  = -1; last_period  = -1;
    last_dir   = 1'bx;
  endtask

  // One clock, then sample 1 ns after the edge and log any valid strobe.
  task automatic step();
    @(posedge div100_clk);
    #1;
    if (valid) begin
      vcount++;
      if (vcount == 1) begin
        first_duty   = int'(duty);
        first_period = int'(period);
      end
      last_duty   = int'(duty);
      last_period = int'(period);
      last_dir    = direct;
    end
  endtask

  task automatic drive(input logic [1:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      MA = code;
      step();
    end
  endtask

  task automatic apply_period(input logic [1:0] code, input int hi, input int lo);
    drive(code, hi);
    drive(2'b11, lo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int since;

    vecs[0] = '{2'b10, 20, 80, 20, 100, 1'b1};
    vecs[1] = '{2'b01, 20, 80, 20, 100, 1'b0};
    vecs[2] = '{2'b10,  1,  9,  1,  10, 1'b1};
    vecs[3] = '{2'b01, 50, 50, 50, 100, 1'b0};
    vecs[4] = '{2'b10, 99,  1, 99, 100, 1'b1};
    vecs[5] = '{2'b10,  3,  7,  3,  10, 1'b1};

    // Reset state
    capture_clear();
    repeat (3) @(posedge div100_clk);
    #1;
    check("rst_duty",   duty,   0);
    check("rst_period", period, 0);
    check("rst_valid",  valid,  0);
    check("rst_direct", direct, 0);
    check("rst_active", active, 0);
    check("rst_stall",  stall,  0);
    s_rst_n = 1'b1;
    step();

    // Steady waveforms: the valid seen during the third period reports the second.
    for (int v = 0; v < 6; v++) begin
`ifdef PWM_DEC_FILTER_EN
      if (vecs[v].hi_len < 3 || vecs[v].lo_len < 3) continue;
`endif
      capture_clear();
      for (int p = 0; p < 3; p++) apply_period(vecs[v].code, vecs[v].hi_len, vecs[v].lo_len);
      check($sformatf("vec%0d_valid_seen", v), vcount > 0, 1);
      check($sformatf("vec%0d_duty", v),   last_duty,   vecs[v].exp_duty);
      check($sformatf("vec%0d_period", v), last_period, vecs[v].exp_period);
      check($sformatf("vec%0d_direct", v), last_dir,    vecs[v].exp_dir);
      check($sformatf("vec%0d_active", v), active,      1);
    end

    // Direction switch mid-period: only the previous period's report appears.
    repeat (2) apply_period(2'b10, 20, 80);
    capture_clear();
    drive(2'b10, 10);
    drive(2'b01, 10);
    drive(2'b11, 80);
    apply_period(2'b01, 20, 80);
    check("switch_valid_count", vcount, 1);
    capture_clear();
    apply_period(2'b01, 20, 80);
    check("after_switch_count",  vcount,      1);
    check("after_switch_duty",   last_duty,   20);
    check("after_switch_period", last_period, 100);
    check("after_switch_direct", last_dir,    0);

    // One-cycle brake glitch inside the high phase.
    repeat (2) apply_period(2'b10, 20, 80);
    drive(2'b10, 10);
    capture_clear();
    drive(2'b11, 1);
    drive(2'b10, 9);
    drive(2'b11, 80);
    drive(2'b10, 8);
`ifdef PWM_DEC_FILTER_EN
    check("glitch_duty",   first_duty,   20);
    check("glitch_period", first_period, 100);
`else
    check("glitch_duty",   first_duty,   10);
    check("glitch_period", first_period, 11);
`endif
    drive(2'b10, 12);
    drive(2'b11, 80);

    // clr on the very cycle a valid would load.
    apply_period(2'b10, 20, 80);
    drive(2'b10, LAT);
    clr = 1'b1;
    MA  = 2'b10;
    step();
    clr = 1'b0;
    check("clr_collide_valid",  valid,  0);
    check("clr_collide_duty",   duty,   0);
    check("clr_collide_period", period, 0);
    drive(2'b10, 20 - LAT - 1);
    drive(2'b11, 80);

    // Stall: brake held after a valid; stall rises exactly TO cycles after it.
    apply_period(2'b10, 20, 80);
    capture_clear();
    since = -1;
    for (int i = 0; i < 20 + TO + 20; i++) begin
      MA = (i < 20) ? 2'b10 : 2'b11;
      step();
      if (since >= 0) since++;
      else if (valid) begin
        since = 0;
        check("stall_pre_duty",   duty,   20);
        check("stall_pre_period", period, 100);
      end
      if (since == TO - 1) check("stall_before_timeout", stall, 0);
      if (since == TO)     check("stall_at_timeout",     stall, 1);
    end
    check("stall_valid_seen", since >= 0, 1);
    check("stall_no_extra_valid", vcount, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_stall",  stall,  0);
    check("clr_duty",   duty,   0);
    check("clr_period", period, 0);

    // Constant 100% duty.
    capture_clear();
    for (int i = 1; i <= TO + LAT + 20; i++) begin
      MA = 2'b10;
      step();
      if (i == TO + LAT)     check("full_duty_before", stall, 0);
      if (i == TO + LAT + 1) check("full_duty_stall",  stall, 1);
    end
    check("full_duty_no_valid", vcount, 0);

    // Stall is sticky across a fresh valid.
    capture_clear();
    repeat (3) apply_period(2'b10, 20, 80);
    check("sticky_valid_seen", vcount > 0, 1);
    check("sticky_stall", stall, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Disable mid-MEAS_LOW, then re-enable.
    apply_period(2'b10, 20, 80);
    drive(2'b10, 20);
    drive(2'b11, 40);
    check("pre_disable_duty", duty, 20);
    drive(2'b00, LAT - 1);
    check("disable_active_early", active, 1);
    drive(2'b00, 1);
    check("disable_active", active, 0);
    check("disable_duty",   duty,   0);
    check("disable_period", period, 0);
    drive(2'b00, 10);
    capture_clear();
    drive(2'b11, 40);
    apply_period(2'b10, 20, 80);
    check("reenable_first_rise_no_valid", vcount, 0);
    capture_clear();
    drive(2'b10, LAT + 3);
    check("reenable_valid_count", vcount,      1);
    check("reenable_duty",        last_duty,   20);
    check("reenable_period",      last_period, 100);
    drive(2'b10, 20 - LAT - 3);
    drive(2'b11, 80);

    // Asynchronous reset mid-MEAS_HIGH.
    apply_period(2'b10, 20, 80);
    drive(2'b10, 10);
    #2;
    s_rst_n = 1'b0;
    #1;
    check("arst_duty",   duty,   0);
    check("arst_period", period, 0);
    check("arst_valid",  valid,  0);
    check("arst_direct", direct, 0);
    check("arst_active", active, 0);
    check("arst_stall",  stall,  0);
    drive(2'b10, 2);
    s_rst_n = 1'b1;
    capture_clear();
    drive(2'b10, 8);
    drive(2'b11, 80);
    apply_period(2'b10, 20, 80);
    check("arst_no_early_valid", vcount, 0);
    capture_clear();
    drive(2'b10, LAT + 3);
    check("arst_valid_count", vcount,      1);
    check("arst_first_duty",  last_duty,   20);
    check("arst_first_period", last_period, 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
